// File: rtl/dma_pkg.sv
// Shared types and CSR map for the multi-channel DMA engine.
package dma_pkg;

  // Slot lifecycle; ST_VALID marks a slot that is free for allocation.
  typedef enum logic [2:0] {
    ST_VALID,
    ST_READING,
    ST_READ_FINISHED,
    ST_WRITING,
    ST_WAIT_RESP
  } STATUS_t;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_MOVE,
    CH_FINISH
  } CH_STATE_t;

  localparam logic [11:0] OFF_EN  = 12'h100;
  localparam logic [11:0] OFF_SRC = 12'h200;
  localparam logic [11:0] OFF_DST = 12'h300;
  localparam logic [11:0] OFF_LEN = 12'h400;

  // CSR address split: channel select above the register offset.
  localparam int CH_LSB  = 12;
  localparam int CH_MSB  = 15;
  localparam int OFF_LSB = 0;
  localparam int OFF_MSB = 11;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter: lowest distance from the priority pointer wins;
// the pointer moves past the winner only when the grant is consumed.
module dma_rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           adv,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           any
);

  logic [IW-1:0] ptr;

  // Scan channels starting at the pointer, first requester wins
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < NCH; i++) begin
      c = (int'(ptr) + i) % NCH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

  // Priority pointer goes to winner+1 modulo NCH on a consumed grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ptr <= '0;
    else if (adv && any)  ptr <= (int'(idx) == NCH - 1) ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/dma_mc.sv
// Multi-channel DMA: NCH channels, round-robin per burst, sharing one read
// and one write master through a DEPTH-slot store-and-forward burst queue.
module dma_mc
  import dma_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DEPTH  = 2,
  parameter int BURST  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [31:0]       address_i,
  input  logic [31:0]       wdata_i,
  output logic [NCH-1:0]    DMA_interrupt_o,
  output logic              READ_REQUEST,
  output logic [ADDR_W-1:0] READ_ADDRESS,
  output logic [3:0]        READ_LEN,
  input  logic              READ_VALID,
  input  logic [DATA_W-1:0] READ_DATA,
  input  logic              READ_FINISH,
  output logic              WRITE_REQUEST,
  output logic [ADDR_W-1:0] WRITE_ADDRESS,
  output logic [3:0]        WRITE_LEN,
  output logic [DATA_W-1:0] WRITE_DATA,
  output logic              WRITE_LAST,
  input  logic              WRITE_VALID,
  input  logic              WRITE_FINISH
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BI = (BURST > 1) ? $clog2(BURST) : 1;

  typedef struct packed {
    logic [IW-1:0]                ch;
    logic [ADDR_W-1:0]            src;
    logic [ADDR_W-1:0]            dst;
    logic [3:0]                   len;   // words-1
    STATUS_t                      st;
    logic [BURST-1:0][DATA_W-1:0] data;
  } slot_t;

  slot_t         slots [DEPTH];
  logic [PW-1:0] aptr, rptr, wptr;
  logic [CW-1:0] cnt;
  logic [3:0]    rbeat, wbeat;

  CH_STATE_t         ch_st  [NCH];
  CH_STATE_t         ch_nxt [NCH];
  logic [ADDR_W-1:0] src_q  [NCH];
  logic [ADDR_W-1:0] dst_q  [NCH];
  logic [31:0]       len_q  [NCH];
  logic [CW-1:0]     outst  [NCH];

  logic [NCH-1:0]    hit, req, gnt;
  logic [IW-1:0]     win;
  logic              any, alloc, free;
  logic [4:0]        wd;
  logic [ADDR_W-1:0] step;
  logic [3:0]        csr_ch;
  logic [11:0]       csr_off;
  logic              addr_hi_unused;

  assign csr_ch         = address_i[CH_MSB:CH_LSB];
  assign csr_off        = address_i[OFF_MSB:OFF_LSB];
  assign addr_hi_unused = ^address_i[31:16];

  // Decode which channel a CSR write targets; out-of-range channels never hit
  always_comb begin
    for (int i = 0; i < NCH; i++) hit[i] = valid_i && (csr_ch == 4'(i));
  end

  dma_rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (alloc),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  // Allocation uses the registered count, so a free in the same cycle
  // cannot open a slot for this cycle's winner.
  assign alloc = any && (cnt < CW'(DEPTH));
  assign free  = (slots[wptr].st == ST_WAIT_RESP) && WRITE_FINISH;

  // Burst size for the current winner: min(LEN, BURST)
  always_comb begin
    wd   = (len_q[win] > 32'(BURST)) ? 5'(BURST) : len_q[win][4:0];
    step = ADDR_W'({wd, 2'b00});
  end

  // Channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < NCH; i++) ch_st[i] <= CH_IDLE;
    else     for (int i = 0; i < NCH; i++) ch_st[i] <= ch_nxt[i];
  end

  // Channel next-state: EN starts, registered LEN/outstanding end, EN acks
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_nxt[i] = ch_st[i];
      case (ch_st[i])
        CH_IDLE:   if (hit[i] && csr_off == OFF_EN && wdata_i[0]) ch_nxt[i] = CH_MOVE;
        CH_MOVE:   if (len_q[i] == '0 && outst[i] == '0)          ch_nxt[i] = CH_FINISH;
        CH_FINISH: if (hit[i] && csr_off == OFF_EN)               ch_nxt[i] = CH_IDLE;
        default:   ch_nxt[i] = CH_IDLE;
      endcase
    end
  end

  // Channel outputs: interrupt in FINISH, burst request while work remains
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      DMA_interrupt_o[i] = (ch_st[i] == CH_FINISH);
      req[i]             = (ch_st[i] == CH_MOVE) && (len_q[i] != '0);
    end
  end

  // Channel CSRs: loaded only in IDLE, advanced per allocated burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        len_q[i] <= '0;
        outst[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_st[i] == CH_IDLE && hit[i]) begin
          if (csr_off == OFF_SRC) src_q[i] <= wdata_i[ADDR_W-1:0];
          if (csr_off == OFF_DST) dst_q[i] <= wdata_i[ADDR_W-1:0];
          if (csr_off == OFF_LEN) len_q[i] <= wdata_i;
        end else if (alloc && gnt[i]) begin
          src_q[i] <= src_q[i] + step;
          dst_q[i] <= dst_q[i] + step;
          len_q[i] <= len_q[i] - 32'(wd);
        end
        case ({alloc && gnt[i], free && (slots[wptr].ch == IW'(i))})
          2'b10:   outst[i] <= outst[i] + 1'b1;
          2'b01:   outst[i] <= outst[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Burst queue: allocation, read engine and write engine each own a pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) slots[d] <= '0;
      aptr  <= '0;
      rptr  <= '0;
      wptr  <= '0;
      cnt   <= '0;
      rbeat <= '0;
      wbeat <= '0;
    end else begin
      if (alloc) begin
        slots[aptr].ch  <= win;
        slots[aptr].src <= src_q[win];
        slots[aptr].dst <= dst_q[win];
        slots[aptr].len <= 4'(wd - 5'd1);
        slots[aptr].st  <= ST_READING;
        aptr            <= aptr + 1'b1;
      end
      // A beat arriving with READ_FINISH is stored before the slot closes
      if (slots[rptr].st == ST_READING) begin
        if (READ_VALID) begin
          slots[rptr].data[rbeat[BI-1:0]] <= READ_DATA;
          rbeat                           <= rbeat + 1'b1;
        end
        if (READ_FINISH) begin
          slots[rptr].st <= ST_READ_FINISHED;
          rbeat          <= '0;
          rptr           <= rptr + 1'b1;
        end
      end
      case (slots[wptr].st)
        ST_READ_FINISHED: slots[wptr].st <= ST_WRITING;
        ST_WRITING: if (WRITE_VALID) begin
          if (wbeat == slots[wptr].len) begin
            slots[wptr].st <= ST_WAIT_RESP;
            wbeat          <= '0;
          end else begin
            wbeat <= wbeat + 1'b1;
          end
        end
        ST_WAIT_RESP: if (WRITE_FINISH) begin
          slots[wptr].st <= ST_VALID;
          wptr           <= wptr + 1'b1;
        end
        default: ;
      endcase
      case ({alloc, free})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Bus outputs are zero whenever the matching request is low
  always_comb begin
    READ_REQUEST  = (slots[rptr].st == ST_READING);
    READ_ADDRESS  = READ_REQUEST ? slots[rptr].src : '0;
    READ_LEN      = READ_REQUEST ? slots[rptr].len : '0;
    WRITE_REQUEST = (slots[wptr].st == ST_WRITING) || (slots[wptr].st == ST_WAIT_RESP);
    WRITE_ADDRESS = WRITE_REQUEST ? slots[wptr].dst : '0;
    WRITE_LEN     = WRITE_REQUEST ? slots[wptr].len : '0;
    WRITE_DATA    = (slots[wptr].st == ST_WRITING) ? slots[wptr].data[wbeat[BI-1:0]] : '0;
    WRITE_LAST    = (slots[wptr].st == ST_WRITING) && (wbeat == slots[wptr].len);
  end

endmodule

// File: tb/tb_dma_mc.sv
// Directed bench for dma_mc with read/write slave models and a scoreboard of
// expected read requests and write beats.
module tb_dma_mc;
  import dma_pkg::*;

  localparam int NCH = 4, DEPTH = 2, BURST = 4, AW = 32, DW = 32;

  logic          clk = 0, rst = 0, valid_i = 0;
  logic [31:0]   address_i = 0, wdata_i = 0;
  logic [NCH-1:0] DMA_interrupt_o;
  logic          READ_REQUEST, WRITE_REQUEST, WRITE_LAST;
  logic [AW-1:0] READ_ADDRESS, WRITE_ADDRESS;
  logic [3:0]    READ_LEN, WRITE_LEN;
  logic [DW-1:0] WRITE_DATA;
  logic          READ_VALID = 0, READ_FINISH = 0, WRITE_VALID = 0, WRITE_FINISH = 0;
  logic [DW-1:0] READ_DATA = 0;

  always #5 clk = ~clk;

  dma_mc #(.NCH(NCH), .DEPTH(DEPTH), .BURST(BURST), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .address_i(address_i), .wdata_i(wdata_i),
    .DMA_interrupt_o(DMA_interrupt_o),
    .READ_REQUEST(READ_REQUEST), .READ_ADDRESS(READ_ADDRESS), .READ_LEN(READ_LEN),
    .READ_VALID(READ_VALID), .READ_DATA(READ_DATA), .READ_FINISH(READ_FINISH),
    .WRITE_REQUEST(WRITE_REQUEST), .WRITE_ADDRESS(WRITE_ADDRESS), .WRITE_LEN(WRITE_LEN),
    .WRITE_DATA(WRITE_DATA), .WRITE_LAST(WRITE_LAST),
    .WRITE_VALID(WRITE_VALID), .WRITE_FINISH(WRITE_FINISH)
  );

  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  int rd_starts = 0, wr_fins = 0, last_fin_cyc = 0;
  bit wr_hold = 0;
  logic [35:0] rd_exp [$];   // {addr, len-1}
  logic [63:0] wr_exp [$];   // {addr, data}

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_burst(input logic [31:0] s, input logic [31:0] d, input int w);
    rd_exp.push_back({s, 4'(w - 1)});
    for (int k = 0; k < w; k++) wr_exp.push_back({d + 32'(k * 4), mem(s + 32'(k * 4))});
  endtask

  // Called at a falling edge; returns at the falling edge after the write is sampled
  task automatic csr(input int ch, input logic [11:0] off, input logic [31:0] d);
    valid_i = 1; address_i = {16'h0, 4'(ch), off}; wdata_i = d;
    @(negedge clk);
    valid_i = 0; address_i = 0; wdata_i = 0;
  endtask

  task automatic program_ch(input int ch, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] len);
    csr(ch, OFF_SRC, s);
    csr(ch, OFF_DST, d);
    csr(ch, OFF_LEN, len);
  endtask

  task automatic wait_irq(input int ch, input string tag);
    int n = 0;
    while (!DMA_interrupt_o[ch] && n < 2000) begin @(negedge clk); n++; end
    chk(tag, 64'(DMA_interrupt_o[ch]), 64'd1);
  endtask

  task automatic chk_drain(input string tag);
    chk({tag, "_rd_left"}, 64'(rd_exp.size()), 64'd0);
    chk({tag, "_wr_left"}, 64'(wr_exp.size()), 64'd0);
  endtask

  // Read slave: random beat gaps, READ_FINISH on the last beat itself
  int rd_idx = 0; bit rd_act = 0; logic [31:0] rd_addr = 0; logic [3:0] rd_len = 0;
  always @(negedge clk) begin
    READ_VALID = 0; READ_FINISH = 0; READ_DATA = 0;
    if (rst) begin
      rd_idx = 0; rd_act = 0;
    end else if (READ_REQUEST) begin
      if (!rd_act) begin
        rd_act = 1; rd_idx = 0; rd_addr = READ_ADDRESS; rd_len = READ_LEN; rd_starts++;
        if (rd_exp.size() == 0) chk("rd_req_unexpected", 64'(rd_exp.size()), 64'd1);
        else chk("rd_req", 64'({READ_ADDRESS, READ_LEN}), 64'(rd_exp.pop_front()));
      end else begin
        chk("rd_hold", 64'({READ_ADDRESS, READ_LEN}), 64'({rd_addr, rd_len}));
      end
      if ($urandom_range(0, 3) != 0) begin
        READ_VALID = 1;
        READ_DATA  = mem(rd_addr + 32'(rd_idx * 4));
        if (rd_idx == int'(rd_len)) begin READ_FINISH = 1; rd_act = 0; end
        rd_idx++;
      end
    end
  end

  // Write slave: random stalls (or full hold), response one cycle after last beat
  int wr_beat = 0; bit wr_resp = 0;
  always @(negedge clk) begin
    WRITE_VALID = 0; WRITE_FINISH = 0;
    if (rst) begin
      wr_beat = 0; wr_resp = 0;
    end else if (WRITE_REQUEST) begin
      if (wr_resp) begin
        WRITE_FINISH = 1; wr_resp = 0; wr_fins++; last_fin_cyc = cyc;
      end else if (!wr_hold && $urandom_range(0, 3) != 0) begin
        WRITE_VALID = 1;
        chk("wr_last", 64'(WRITE_LAST), 64'(wr_beat == int'(WRITE_LEN)));
        if (wr_exp.size() == 0) chk("wr_unexpected", 64'(wr_exp.size()), 64'd1);
        else chk("wr_beat", {WRITE_ADDRESS + 32'(wr_beat * 4), WRITE_DATA}, wr_exp.pop_front());
        if (wr_beat == int'(WRITE_LEN)) begin wr_beat = 0; wr_resp = 1; end
        else wr_beat++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0;
    // Reset state
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'({READ_REQUEST, WRITE_REQUEST, WRITE_LAST, DMA_interrupt_o,
                          READ_LEN, WRITE_LEN, READ_ADDRESS}), 64'd0);
    chk("reset_wr_bus", {WRITE_ADDRESS, WRITE_DATA}, 64'd0);
    rst = 0;
    @(negedge clk);

    // Single channel: 10 words as 4/4/2, plus an ignored SRC/LEN write while busy
    program_ch(0, 32'h1000, 32'h2000, 32'd10);
    push_burst(32'h1000, 32'h2000, 4);
    push_burst(32'h1010, 32'h2010, 4);
    push_burst(32'h1020, 32'h2020, 2);
    csr(0, OFF_EN, 32'd1);
    chk("move_no_req_yet", 64'(READ_REQUEST), 64'd0);
    @(negedge clk);
    chk("first_rd_req", 64'({READ_REQUEST, READ_ADDRESS}), 64'({1'b1, 32'h1000}));
    csr(0, OFF_SRC, 32'hDEAD0000);
    csr(0, OFF_LEN, 32'd3);
    wait_irq(0, "irq0_single");
    chk("irq_two_after_finish", 64'(cyc), 64'(last_fin_cyc + 2));
    chk_drain("single");

    // Interrupt clear returns the channel to IDLE
    csr(0, OFF_EN, 32'd0);
    chk("irq_clear", 64'(DMA_interrupt_o), 64'd0);

    // Zero-length start: FINISH the cycle after MOVE, no bus traffic
    r0 = rd_starts;
    program_ch(2, 32'h5000, 32'h6000, 32'd0);
    csr(2, OFF_EN, 32'd1);
    chk("zl_move", 64'(DMA_interrupt_o[2]), 64'd0);
    @(negedge clk);
    chk("zl_irq", 64'(DMA_interrupt_o[2]), 64'd1);
    chk("zl_no_bus", 64'({READ_REQUEST, WRITE_REQUEST, 32'(rd_starts - r0)}), 64'd0);
    csr(2, OFF_EN, 32'd0);

    // Two channels enabled back to back: bursts alternate ch0, ch1
    program_ch(0, 32'h3000, 32'h7000, 32'd8);
    program_ch(1, 32'h4000, 32'h8000, 32'd8);
    push_burst(32'h3000, 32'h7000, 4);
    push_burst(32'h4000, 32'h8000, 4);
    push_burst(32'h3010, 32'h7010, 4);
    push_burst(32'h4010, 32'h8010, 4);
    csr(0, OFF_EN, 32'd1);
    csr(1, OFF_EN, 32'd1);
    wait_irq(0, "irq0_dual");
    wait_irq(1, "irq1_dual");
    chk_drain("dual");
    csr(0, OFF_EN, 32'd0);
    csr(1, OFF_EN, 32'd0);
    chk("dual_irq_clear", 64'(DMA_interrupt_o), 64'd0);

    // Backpressure: writes held, only DEPTH bursts may be read
    wr_hold = 1;
    program_ch(3, 32'h9000, 32'hA000, 32'd16);
    for (int b = 0; b < 4; b++) push_burst(32'h9000 + 32'(b * 16), 32'hA000 + 32'(b * 16), 4);
    r0 = rd_starts; f0 = wr_fins;
    csr(3, OFF_EN, 32'd1);
    repeat (40) @(negedge clk);
    chk("bp_two_reads", 64'(rd_starts - r0), 64'd2);
    chk("bp_no_third_req", 64'(READ_REQUEST), 64'd0);
    chk("bp_no_finish", 64'(wr_fins - f0), 64'd0);
    wr_hold = 0;
    wait_irq(3, "irq3_bp");
    chk_drain("bp");
    csr(3, OFF_EN, 32'd0);

    // Reset in the middle of a read burst, then a clean reprogram
    program_ch(0, 32'hB000, 32'hC000, 32'd8);
    push_burst(32'hB000, 32'hC000, 4);
    push_burst(32'hB010, 32'hC010, 4);
    csr(0, OFF_EN, 32'd1);
    for (int n = 0; n < 50 && !READ_VALID; n++) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_async_outs", 64'({READ_REQUEST, WRITE_REQUEST, WRITE_LAST, DMA_interrupt_o,
                              READ_LEN, WRITE_LEN, READ_ADDRESS}), 64'd0);
    rd_exp.delete();
    wr_exp.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_no_irq", 64'(DMA_interrupt_o), 64'd0);
    program_ch(0, 32'hB000, 32'hC000, 32'd6);
    push_burst(32'hB000, 32'hC000, 4);
    push_burst(32'hB010, 32'hC010, 2);
    csr(0, OFF_EN, 32'd1);
    wait_irq(0, "irq0_after_rst");
    chk_drain("after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
